// File: rtl/pp_seq_pkg.sv
// Shared constants, state type and truncation helper
// for the sequential 6x6 shift-add multiplier.
package pp_seq_pkg;

    localparam int OP_W   = 6;
    localparam int ADD_W  = 11;
    localparam int PROD_W = ADD_W + 1;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Ones everywhere except the low trunc columns.
    function automatic logic [ADD_W-1:0] row_mask(input int trunc);
        logic [ADD_W-1:0] m;
        m = '1;
        for (int i = 0; i < ADD_W; i++) begin
            if (i < trunc) m[i] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/pp_row_gen.sv
// Partial-product row generator: shifted multiplicand
// gated by one multiplier bit, low columns truncated.
module pp_row_gen
    import pp_seq_pkg::*;
#(
    parameter int TRUNC_LSB = 0
) (
    input  logic [OP_W-1:0]  a_i,
    input  logic [OP_W-1:0]  b_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [ADD_W-1:0] row_o
);

    localparam logic [ADD_W-1:0] MASK = row_mask(TRUNC_LSB);

    logic [7:0]       b_ext;
    logic [ADD_W-1:0] shifted;

    always_comb begin
        b_ext   = {2'b00, b_i};
        shifted = {{(ADD_W-OP_W){1'b0}}, a_i} << cnt_i;
        row_o   = b_ext[cnt_i] ? (shifted & MASK) : '0;
    end

endmodule

// File: rtl/pp_seq_mult6.sv
// Sequential 6x6 shift-add multiplier front end driving
// an external 11-bit adder, with valid/ready handshakes.
module pp_seq_mult6
    import pp_seq_pkg::*;
#(
    parameter int TRUNC_LSB = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_prod,
    output logic [ADD_W-1:0]  add_a,
    output logic [ADD_W-1:0]  add_b,
    input  logic [ADD_W-1:0]  add_sum,
    input  logic              add_cout
);

    state_e             state_q, state_d;
    logic [PROD_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [ADD_W-1:0]   row;

    pp_row_gen #(
        .TRUNC_LSB(TRUNC_LSB)
    ) u_row (
        .a_i  (a_q),
        .b_i  (b_q),
        .cnt_i(cnt_q),
        .row_o(row)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_prod  = '0;
        add_a     = '0;
        add_b     = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // acc[11] is provably zero until the last add
                add_a = acc_q[ADD_W-1:0];
                add_b = row;
                acc_d = {add_cout, add_sum};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == 3'd5) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_prod  = acc_q;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
